// File: rtl/lsu_dmem_bridge_pkg.sv
// Shared types and default region constants for the LSU data-memory bridge
// and the address region checker it uses.
package lsu_dmem_bridge_pkg;

  typedef enum logic [2:0] {
    DMEM_ST_IDLE,
    DMEM_ST_REQ,
    DMEM_ST_WAIT,
    DMEM_ST_RESP,
    DMEM_ST_MAINT
  } dmem_state_e;

  localparam logic [31:0] DMEM_BASE_DEF    = 32'h0000_0000;
  localparam logic [31:0] DMEM_LIMIT_DEF   = 32'h0000_FFFF;
  localparam logic [31:0] DMEM_RO_BASE_DEF = 32'h0000_0000;
  localparam logic [31:0] DMEM_RO_LIMIT_DEF = 32'h0000_0FFF;
  localparam int unsigned DMEM_TIMEOUT_DEF = 255;

  // Maintenance bit order: [0] flush, [1] writeback, [2] invalidate.
  function automatic logic [2:0] maint_pick(input logic [2:0] pend);
    if (pend[0]) return 3'b001;
    if (pend[1]) return 3'b010;
    if (pend[2]) return 3'b100;
    return 3'b000;
  endfunction

endpackage

// File: rtl/lsu_dmem_bridge_region_check.sv
// Combinational legality check of a word address against the data region
// and the read-only window; shared with the fetch-side bridge.
module dmem_region_check
  import lsu_dmem_bridge_pkg::*;
#(
  parameter logic [31:0] DMEM_BASE  = DMEM_BASE_DEF,
  parameter logic [31:0] DMEM_LIMIT = DMEM_LIMIT_DEF,
  parameter logic [31:0] RO_BASE    = DMEM_RO_BASE_DEF,
  parameter logic [31:0] RO_LIMIT   = DMEM_RO_LIMIT_DEF
) (
  input  logic [31:0] addr,
  input  logic        wr,
  output logic        out_of_range,
  output logic        ro_violation
);

  localparam logic        DMEM_EN   = (DMEM_LIMIT >= DMEM_BASE);
  localparam logic        RO_EN     = (RO_LIMIT >= RO_BASE);
  localparam logic [31:0] DMEM_SPAN = DMEM_LIMIT - DMEM_BASE;
  localparam logic [31:0] RO_SPAN   = RO_LIMIT - RO_BASE;

  logic [31:0] dmem_off;
  logic [31:0] ro_off;

  // Offset-from-base compare gives an inclusive unsigned range test with one comparator.
  assign dmem_off     = addr - DMEM_BASE;
  assign ro_off       = addr - RO_BASE;
  assign out_of_range = !DMEM_EN || (dmem_off > DMEM_SPAN);
  assign ro_violation = wr && RO_EN && (ro_off <= RO_SPAN);

endmodule

// File: rtl/lsu_dmem_bridge.sv
// LSU-to-data-memory bridge: region check, bus handshake with timeout, one
// response per access, and queued cache-maintenance commands.
module lsu_dmem_bridge
  import lsu_dmem_bridge_pkg::*;
#(
  parameter logic [31:0] DMEM_BASE  = DMEM_BASE_DEF,
  parameter logic [31:0] DMEM_LIMIT = DMEM_LIMIT_DEF,
  parameter logic [31:0] RO_BASE    = DMEM_RO_BASE_DEF,
  parameter logic [31:0] RO_LIMIT   = DMEM_RO_LIMIT_DEF,
  parameter int unsigned TIMEOUT    = DMEM_TIMEOUT_DEF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_data_i,
  input  logic        lsu_rd_i,
  input  logic        lsu_wr_i,
  input  logic [3:0]  lsu_mask_i,
  input  logic        lsu_dflush_i,
  input  logic        lsu_dwriteback_i,
  input  logic        lsu_dinvalidate_i,
  output logic [31:0] lsu_value_o,
  output logic        lsu_valid_o,
  output logic        lsu_load_fault_o,
  output logic        lsu_store_fault_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_data_wr_o,
  output logic [3:0]  mem_mask_o,
  output logic        mem_rd_o,
  output logic        mem_wr_o,
  input  logic        mem_accept_i,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_data_rd_i,
  input  logic        mem_error_i,
  output logic        mem_flush_o,
  output logic        mem_writeback_o,
  output logic        mem_invalidate_o,
  input  logic        mem_maint_done_i,
  output logic        maint_busy_o
);

  localparam int unsigned      CNT_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  dmem_state_e      state;
  logic             resp_q;
  logic             wr_q;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       pend;
  logic [2:0]       maint_cmd;
  logic [2:0]       maint_sel;
  logic [2:0]       maint_clr;
  logic [2:0]       maint_strobe;
  logic             lsu_req;
  logic             capture;
  logic             timed_out;
  logic             out_of_range;
  logic             ro_violation;

  dmem_region_check #(
    .DMEM_BASE  (DMEM_BASE),
    .DMEM_LIMIT (DMEM_LIMIT),
    .RO_BASE    (RO_BASE),
    .RO_LIMIT   (RO_LIMIT)
  ) u_region (
    .addr         (lsu_addr_i),
    .wr           (lsu_wr_i),
    .out_of_range (out_of_range),
    .ro_violation (ro_violation)
  );

  assign lsu_req      = lsu_rd_i | lsu_wr_i;
  // The LSU still holds its request in the cycle after RESP; never re-capture it.
  assign capture      = (state == DMEM_ST_IDLE) && lsu_req && !resp_q;
  assign timed_out    = (TIMEOUT != 0) && (cnt == CNT_LAST);
  assign maint_strobe = {lsu_dinvalidate_i, lsu_dwriteback_i, lsu_dflush_i};
  assign maint_cmd    = {mem_invalidate_o, mem_writeback_o, mem_flush_o};
  assign maint_sel    = maint_pick(pend);
  assign maint_clr    = (state == DMEM_ST_MAINT && mem_maint_done_i) ? maint_cmd : 3'b000;
  assign maint_busy_o = (|pend) || (state == DMEM_ST_MAINT);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state             <= DMEM_ST_IDLE;
      resp_q            <= 1'b0;
      wr_q              <= 1'b0;
      cnt               <= '0;
      pend              <= 3'b000;
      lsu_value_o       <= '0;
      lsu_valid_o       <= 1'b0;
      lsu_load_fault_o  <= 1'b0;
      lsu_store_fault_o <= 1'b0;
      mem_addr_o        <= '0;
      mem_data_wr_o     <= '0;
      mem_mask_o        <= '0;
      mem_rd_o          <= 1'b0;
      mem_wr_o          <= 1'b0;
      mem_flush_o       <= 1'b0;
      mem_writeback_o   <= 1'b0;
      mem_invalidate_o  <= 1'b0;
    end else begin
      pend              <= (pend | maint_strobe) & ~maint_clr;
      resp_q            <= (state == DMEM_ST_RESP);
      lsu_value_o       <= '0;
      lsu_valid_o       <= 1'b0;
      lsu_load_fault_o  <= 1'b0;
      lsu_store_fault_o <= 1'b0;
      if (state == DMEM_ST_REQ || state == DMEM_ST_WAIT) begin
        cnt <= sat_inc(cnt);
      end

      case (state)
        DMEM_ST_IDLE: begin
          if (capture) begin
            mem_addr_o    <= lsu_addr_i;
            mem_data_wr_o <= lsu_data_i;
            mem_mask_o    <= lsu_mask_i;
            wr_q          <= lsu_wr_i;
            cnt           <= '0;
            if (out_of_range || ro_violation) begin
              state             <= DMEM_ST_RESP;
              lsu_valid_o       <= 1'b1;
              lsu_load_fault_o  <= !lsu_wr_i;
              lsu_store_fault_o <= lsu_wr_i;
            end else begin
              state    <= DMEM_ST_REQ;
              mem_rd_o <= !lsu_wr_i;
              mem_wr_o <= lsu_wr_i;
            end
          end else if (!lsu_req && (|pend)) begin
            state <= DMEM_ST_MAINT;
            {mem_invalidate_o, mem_writeback_o, mem_flush_o} <= maint_sel;
          end
        end

        DMEM_ST_REQ: begin
          if (timed_out) begin
            state             <= DMEM_ST_RESP;
            mem_rd_o          <= 1'b0;
            mem_wr_o          <= 1'b0;
            lsu_valid_o       <= 1'b1;
            lsu_load_fault_o  <= !wr_q;
            lsu_store_fault_o <= wr_q;
          end else if (mem_accept_i) begin
            state    <= DMEM_ST_WAIT;
            mem_rd_o <= 1'b0;
            mem_wr_o <= 1'b0;
          end
        end

        DMEM_ST_WAIT: begin
          if (mem_ack_i) begin
            state             <= DMEM_ST_RESP;
            lsu_valid_o       <= 1'b1;
            lsu_load_fault_o  <= mem_error_i && !wr_q;
            lsu_store_fault_o <= mem_error_i && wr_q;
            lsu_value_o       <= (wr_q || mem_error_i) ? '0 : mem_data_rd_i;
          end else if (timed_out) begin
            state             <= DMEM_ST_RESP;
            lsu_valid_o       <= 1'b1;
            lsu_load_fault_o  <= !wr_q;
            lsu_store_fault_o <= wr_q;
          end
        end

        DMEM_ST_RESP: begin
          state <= DMEM_ST_IDLE;
        end

        DMEM_ST_MAINT: begin
          if (mem_maint_done_i) begin
            state            <= DMEM_ST_IDLE;
            mem_flush_o      <= 1'b0;
            mem_writeback_o  <= 1'b0;
            mem_invalidate_o <= 1'b0;
          end
        end

        default: state <= DMEM_ST_IDLE;
      endcase
    end
  end

endmodule
